// File: rtl/dma_pkg.sv
// Shared types and burst-sizing helper for the DMA read/write streamers.
package dma_pkg;

    localparam int unsigned DMA_ADDR_W = 32;
    localparam int unsigned DMA_LEN_W  = 32;
    localparam int unsigned DMA_DATA_W = 32;
    localparam int unsigned DMA_STRB_W = DMA_DATA_W / 8;
    localparam int unsigned DMA_OFF_W  = $clog2(DMA_STRB_W);
    localparam int unsigned AXI_4KB    = 4096;

    typedef struct packed {
        logic                  valid;
        logic [DMA_ADDR_W-1:0] addr;
        logic [7:0]            alen;
        logic [2:0]            size;
        logic [DMA_STRB_W-1:0] strb;
    } s_dma_axi_req_t;

    typedef struct packed {
        logic ready;
    } s_dma_axi_resp_t;

    typedef enum logic [1:0] {IDLE, BURST, TAIL, DONE} stream_state_t;

    // Largest legal burst: limited by MAX_BEATS, whole beats left and the next 4 KB page.
    function automatic logic [8:0] calc_burst_beats(input logic [11:0]          addr_lo,
                                                    input logic [DMA_LEN_W-1:0] rem,
                                                    input logic [8:0]           max_beats);
        logic [DMA_LEN_W-1:0] beats_left;
        logic [12:0]          to4k;
        logic [12:0]          beats;
        beats_left = rem >> DMA_OFF_W;
        to4k       = (13'(AXI_4KB) - {1'b0, addr_lo}) >> DMA_OFF_W;
        beats      = {4'd0, max_beats};
        if (to4k < beats) beats = to4k;
        if (beats_left < DMA_LEN_W'(beats)) beats = 13'(beats_left);
        return beats[8:0];
    endfunction

endpackage

// File: rtl/dma_burst_calc.sv
// Combinational burst sizing: alen, byte advance and tail strobe from the current address/remainder.
module dma_burst_calc
    import dma_pkg::*;
#(
    parameter int unsigned LEN_W     = 32,
    parameter int unsigned MAX_BEATS = 256
) (
    input  logic [11:0]           addr_lo_i,
    input  logic [LEN_W-1:0]      rem_i,
    output logic [7:0]            alen_o,
    output logic [DMA_STRB_W-1:0] strb_o,
    output logic [LEN_W-1:0]      bytes_o
);

    localparam logic [DMA_STRB_W:0] STRB_ONE = 1;

    logic [8:0] beats;

    assign beats   = calc_burst_beats(addr_lo_i, DMA_LEN_W'(rem_i), 9'(MAX_BEATS));
    assign alen_o  = 8'(beats - 9'd1);
    assign bytes_o = LEN_W'(beats) << DMA_OFF_W;
    // Only meaningful in TAIL, where rem is 1..BYTES-1.
    assign strb_o  = DMA_STRB_W'((STRB_ONE << rem_i[DMA_OFF_W-1:0]) - STRB_ONE);

endmodule

// File: rtl/dma_burst_streamer.sv
// Turns one (address, byte count) descriptor into a sequence of AXI INCR burst requests.
module dma_burst_streamer
    import dma_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LEN_W     = 32,
    parameter int unsigned MAX_BEATS = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LEN_W-1:0]  num_bytes_i,
    input  logic            dma_active_i,
    input  logic            clear_dma_i,
    output s_dma_axi_req_t  dma_axi_req_o,
    input  s_dma_axi_resp_t dma_axi_resp_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            cfg_err_o,
    output logic [15:0]     txn_cnt_o
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);

    stream_state_t     state_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [LEN_W-1:0]  rem_q;
    logic [15:0]       txn_cnt_q;
    logic              done_q;
    logic              cfg_err_q;
    logic              abort_q;

    logic [7:0]            burst_alen;
    logic [DMA_STRB_W-1:0] tail_strb;
    logic [LEN_W-1:0]      burst_bytes;
    logic [ADDR_W-1:0]     cur_addr_d;
    logic [LEN_W-1:0]      rem_d;
    logic                  in_xfer;
    logic                  handshake;

    dma_burst_calc #(
        .LEN_W     (LEN_W),
        .MAX_BEATS (MAX_BEATS)
    ) u_calc (
        .addr_lo_i (cur_addr_q[11:0]),
        .rem_i     (rem_q),
        .alen_o    (burst_alen),
        .strb_o    (tail_strb),
        .bytes_o   (burst_bytes)
    );

    assign in_xfer    = (state_q == BURST) || (state_q == TAIL);
    assign handshake  = in_xfer && dma_active_i && dma_axi_resp_i.ready;
    assign cur_addr_d = cur_addr_q + ADDR_W'(burst_bytes);
    assign rem_d      = rem_q - burst_bytes;

    // Payload depends only on registers, so it cannot move while a request waits for ready.
    always_comb begin
        // NOTE: default every field first so no path through this block infers a latch.
        dma_axi_req_o = '0;
        if (in_xfer) begin
            dma_axi_req_o.valid = dma_active_i;
            dma_axi_req_o.addr  = DMA_ADDR_W'(cur_addr_q);
            dma_axi_req_o.size  = 3'(OFF_W);
            dma_axi_req_o.alen  = (state_q == BURST) ? burst_alen : 8'd0;
            dma_axi_req_o.strb  = (state_q == BURST) ? '1 : tail_strb;
        end
    end

    // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            rem_q      <= '0;
            txn_cnt_q  <= '0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    abort_q <= 1'b0;
                    if (start_i) begin
                        if (addr_i[OFF_W-1:0] != '0) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            cur_addr_q <= addr_i;
                            rem_q      <= num_bytes_i;
                            txn_cnt_q  <= '0;
                            if (num_bytes_i == '0)                state_q <= DONE;
                            else if (num_bytes_i < LEN_W'(BYTES)) state_q <= TAIL;
                            else                                  state_q <= BURST;
                        end
                    end
                end
                BURST, TAIL: begin
                    if (!dma_active_i) begin
                        state_q <= IDLE;
                        abort_q <= 1'b0;
                    end else if (handshake) begin
                        if (txn_cnt_q != 16'hFFFF) txn_cnt_q <= txn_cnt_q + 16'd1;
                        abort_q <= 1'b0;
                        if (state_q == BURST) begin
                            cur_addr_q <= cur_addr_d;
                            rem_q      <= rem_d;
                        end
                        if (clear_dma_i || abort_q)           state_q <= IDLE;
                        else if (state_q == TAIL)             state_q <= DONE;
                        else if (rem_d >= LEN_W'(BYTES))      state_q <= BURST;
                        else if (rem_d != '0)                 state_q <= TAIL;
                        else                                  state_q <= DONE;
                    end else if (clear_dma_i) begin
                        // Request already visible: finish the handshake, then abandon the descriptor.
                        abort_q <= 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= dma_active_i;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;
    assign cfg_err_o = cfg_err_q;
    assign txn_cnt_o = txn_cnt_q;

endmodule

// File: tb/tb_dma_burst_streamer.sv
// Directed bench for dma_burst_streamer with hand-computed burst sequences.
module tb_dma_burst_streamer;
    import dma_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_i = 1'b0;
    logic [31:0]     addr_i = '0;
    logic [31:0]     num_bytes_i = '0;
    logic            dma_active_i = 1'b1;
    logic            clear_dma_i = 1'b0;
    s_dma_axi_req_t  req;
    s_dma_axi_resp_t resp;
    logic            busy_o, done_o, cfg_err_o;
    logic [15:0]     txn_cnt_o;

    int tests_run = 0;
    int tests_failed = 0;
    s_dma_axi_req_t reqs[$];
    int cyc = 0, hs_cyc = 0, done_cyc = 0, done_cnt = 0, valid_cnt = 0;
    int d0, v0;

    dma_burst_streamer #(
        .DATA_W(32), .ADDR_W(32), .LEN_W(32), .MAX_BEATS(256)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .addr_i         (addr_i),
        .num_bytes_i    (num_bytes_i),
        .dma_active_i   (dma_active_i),
        .clear_dma_i    (clear_dma_i),
        .dma_axi_req_o  (req),
        .dma_axi_resp_i (resp),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .cfg_err_o      (cfg_err_o),
        .txn_cnt_o      (txn_cnt_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (req.valid && resp.ready) begin
            reqs.push_back(req);
            hs_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (req.valid) valid_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_desc(input logic [31:0] a, input logic [31:0] n);
        @(negedge clk);
        addr_i      = a;
        num_bytes_i = n;
        start_i     = 1'b1;
        @(negedge clk);
        start_i     = 1'b0;
    endtask

    task automatic run_desc(input string tag, input logic [31:0] a, input logic [31:0] n);
        reqs.delete();
        start_desc(a, n);
        for (int i = 0; i < 3000 && busy_o; i++) @(negedge clk);
        check({tag, "_finished"}, busy_o, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_req(input string tag, input int idx, input logic [31:0] a,
                              input logic [7:0] alen, input logic [3:0] strb);
        if (idx < reqs.size()) begin
            check({tag, "_addr"}, reqs[idx].addr, a);
            check({tag, "_alen"}, reqs[idx].alen, alen);
            check({tag, "_size"}, reqs[idx].size, 3'd2);
            check({tag, "_strb"}, reqs[idx].strb, strb);
        end else begin
            check({tag, "_present"}, reqs.size(), idx + 1);
        end
    endtask

    initial begin
        resp.ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req", req, '0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_txn", txn_cnt_o, 16'd0);
        rst = 1'b0;

        // 1: single aligned burst
        d0 = done_cnt;
        run_desc("c1", 32'h1000, 32'd64);
        check("c1_count", reqs.size(), 1);
        expect_req("c1_r0", 0, 32'h1000, 8'd15, 4'hF);
        check("c1_done_cnt", done_cnt - d0, 1);
        check("c1_done_lat", done_cyc - hs_cyc, 1);
        check("c1_txn", txn_cnt_o, 16'd1);

        // 2: split at the 4 KB page
        run_desc("c2", 32'h0FF0, 32'd64);
        check("c2_count", reqs.size(), 2);
        expect_req("c2_r0", 0, 32'h0FF0, 8'd3, 4'hF);
        expect_req("c2_r1", 1, 32'h1000, 8'd11, 4'hF);

        // 3: split at MAX_BEATS
        run_desc("c3", 32'h2000, 32'd2048);
        check("c3_count", reqs.size(), 2);
        expect_req("c3_r0", 0, 32'h2000, 8'd255, 4'hF);
        expect_req("c3_r1", 1, 32'h2400, 8'd255, 4'hF);
        check("c3_txn", txn_cnt_o, 16'd2);

        // 4: unaligned byte tail
        run_desc("c4", 32'h3000, 32'd10);
        check("c4_count", reqs.size(), 2);
        expect_req("c4_r0", 0, 32'h3000, 8'd1, 4'hF);
        expect_req("c4_r1", 1, 32'h3008, 8'd0, 4'h3);
        check("c4_txn", txn_cnt_o, 16'd2);

        // 5: back-pressure then clear while the request is pending
        reqs.delete();
        d0 = done_cnt;
        resp.ready = 1'b0;
        start_desc(32'h2000, 32'd2048);
        for (int i = 0; i < 5; i++) begin
            check("c5_hold_valid", req.valid, 1'b1);
            check("c5_hold_addr", req.addr, 32'h2000);
            check("c5_hold_alen", req.alen, 8'd255);
            check("c5_hold_strb", req.strb, 4'hF);
            @(negedge clk);
        end
        clear_dma_i = 1'b1;
        @(negedge clk);
        clear_dma_i = 1'b0;
        check("c5_clr_valid", req.valid, 1'b1);
        check("c5_clr_addr", req.addr, 32'h2000);
        check("c5_clr_alen", req.alen, 8'd255);
        resp.ready = 1'b1;
        @(negedge clk);
        check("c5_idle", busy_o, 1'b0);
        check("c5_txn", txn_cnt_o, 16'd1);
        repeat (4) @(negedge clk);
        check("c5_count", reqs.size(), 1);
        check("c5_no_done", done_cnt - d0, 0);

        // 6a: misaligned start address
        v0 = valid_cnt;
        start_desc(32'h3002, 32'd16);
        check("c6a_err", cfg_err_o, 1'b1);
        check("c6a_busy", busy_o, 1'b0);
        @(negedge clk);
        check("c6a_err_pulse", cfg_err_o, 1'b0);
        repeat (2) @(negedge clk);
        check("c6a_no_valid", valid_cnt - v0, 0);

        // 6b: zero-length descriptor
        reqs.delete();
        start_desc(32'h4000, 32'd0);
        check("c6b_done_early", done_o, 1'b0);
        @(negedge clk);
        check("c6b_done", done_o, 1'b1);
        @(negedge clk);
        check("c6b_done_pulse", done_o, 1'b0);
        check("c6b_no_req", reqs.size(), 0);

        // dma_active_i low drops valid immediately and aborts without done
        reqs.delete();
        d0 = done_cnt;
        resp.ready = 1'b0;
        start_desc(32'h1000, 32'd64);
        check("act_valid", req.valid, 1'b1);
        dma_active_i = 1'b0;
        #1;
        check("act_drop", req.valid, 1'b0);
        @(negedge clk);
        check("act_idle", busy_o, 1'b0);
        dma_active_i = 1'b1;
        resp.ready = 1'b1;
        repeat (3) @(negedge clk);
        check("act_no_done", done_cnt - d0, 0);
        check("act_no_req", reqs.size(), 0);

        // 6c: async reset mid-BURST
        start_desc(32'h2000, 32'd4096);
        @(negedge clk);
        check("c6c_pre_valid", req.valid, 1'b1);
        check("c6c_pre_txn", txn_cnt_o, 16'd1);
        #2 rst = 1'b1;
        #1;
        check("c6c_req", req, '0);
        check("c6c_busy", busy_o, 1'b0);
        check("c6c_txn", txn_cnt_o, 16'd0);
        check("c6c_done", done_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dma_burst_streamer.md
Name: dma_burst_streamer

Overview:
Sequencer that converts one DMA descriptor (start address, byte count) into a stream of AXI4 INCR burst requests on the s_dma_axi_req_t / s_dma_axi_resp_t streamer interface of the DMA AXI master. Bursts are split at MAX_BEATS and at 4 KB boundaries, and an unaligned byte tail becomes a final single-beat burst with a partial strobe. One instance serves the read side and one serves the write side; the DMA FSM starts both.

Parameters:
DATA_W, 32, AXI data width in bits; BYTES = DATA_W/8 bytes per beat
ADDR_W, 32, address width
LEN_W, 32, descriptor byte-count width
MAX_BEATS, 256, maximum beats per burst (power of two, 1..256)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start_i  in  1  one-cycle pulse; latches the descriptor when in IDLE, ignored otherwise
addr_i  in  ADDR_W  descriptor start address
num_bytes_i  in  LEN_W  descriptor byte count
dma_active_i  in  1  DMA enabled; when low, valid is dropped immediately
clear_dma_i  in  1  abort/clear request from the DMA FSM
dma_axi_req_o  out  $bits(s_dma_axi_req_t)  fields valid, addr, alen, size, strb
dma_axi_resp_i  in  $bits(s_dma_axi_resp_t)  field ready (address-channel handshake)
busy_o  out  1  high while not in IDLE
done_o  out  1  one-cycle pulse when the descriptor is complete
cfg_err_o  out  1  one-cycle pulse when a descriptor is rejected
txn_cnt_o  out  16  bursts issued for the current descriptor (saturating)

Behaviour:
- Reset (asynchronous, any state): state IDLE; all outputs 0; internal address/remaining registers 0.
- States: IDLE, BURST, TAIL, DONE.
- IDLE, start_i=1:
  - addr_i not BYTES-aligned: pulse cfg_err_o next cycle, stay IDLE.
  - num_bytes_i == 0: go to DONE (done_o pulses the following cycle, no request issued).
  - num_bytes_i < BYTES: go to TAIL.
  - otherwise: go to BURST.
  - In all accepted cases latch cur_addr=addr_i, rem=num_bytes_i and clear txn_cnt_o.
- BURST:
  - beats_left = rem >> log2(BYTES); to4k = (4096 - cur_addr[11:0]) >> log2(BYTES).
  - beats = min(MAX_BEATS, beats_left, to4k).
  - Drive valid=1, addr=cur_addr, alen=beats-1, size=log2(BYTES), strb=all ones. Payload is computed from registers only.
  - On handshake (valid && ready): cur_addr += beats*BYTES; rem -= beats*BYTES; txn_cnt++.
  - Next state: BURST if the new rem >= BYTES, else TAIL if rem != 0, else DONE.
- TAIL: valid=1, addr=cur_addr, alen=0, strb=(1<<rem)-1 (rem in 1..BYTES-1). On handshake: txn_cnt++, go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Handshake rule: once valid rises, addr/alen/size/strb stay stable until ready. valid may only drop without a handshake when dma_active_i=0.
- clear_dma_i in BURST/TAIL:
  - If valid is pending without ready, hold the request until the handshake (or until dma_active_i=0), then go to IDLE with no done_o.
  - Otherwise go to IDLE next cycle.
- dma_active_i=0 in any non-IDLE state: valid=0 combinationally; state goes to IDLE next cycle; no done_o.
- Simultaneous clear_dma_i and final handshake: the handshake counts, state goes to IDLE, done_o is suppressed.
- Arithmetic: rem and the address update use LEN_W / ADDR_W unsigned arithmetic. Address wrap past 2^ADDR_W is not guarded; the FSM rejects such descriptors upstream. txn_cnt_o saturates at 0xFFFF.

Decomposition:
- dma_pkg holds s_dma_axi_req_t, s_dma_axi_resp_t, a stream_state_t enum (IDLE/BURST/TAIL/DONE), the constant AXI_4KB=4096, and a function calc_burst_beats(addr, rem, max) returning beats.
- Sub-module dma_burst_calc: combinational beats/alen/strb computation. It is reused by both read and write instances and unit-tested standalone.

Test Plan:
1. DATA_W=32, addr 0x1000, 64 bytes, ready=1 -> one request addr 0x1000 alen 15 size 2 strb 0xF; done_o pulses 1 cycle after the handshake; txn_cnt_o=1.
2. addr 0x0FF0, 64 bytes -> requests (0x0FF0, alen 3) then (0x1000, alen 11); no burst crosses 0x1000.
3. addr 0x2000, 2048 bytes -> (0x2000, alen 255) then (0x2400, alen 255); txn_cnt_o=2.
4. addr 0x3000, 10 bytes -> (0x3000, alen 1, strb 0xF) then (0x3008, alen 0, strb 0x3).
5. ready held low 5 cycles on the first burst of case 3 -> valid and payload unchanged all 5 cycles. Then clear_dma_i for one cycle while ready=0 -> request held until ready, state goes to IDLE, no second burst, no done_o.
6. Edge cases:
   - addr 0x3002 -> cfg_err_o pulse, valid never asserts.
   - num_bytes 0 -> done_o 2 cycles after start_i, no request.
   - Async rst mid-BURST -> all outputs 0 immediately.
